// File: rtl/ex_muldiv.sv
// RV32M iterative multiply/divide for EX; `define FAST_MUL_EN for a single-cycle multiply.
// Latency: done 33 cycles after accept (1 for divide special cases and fast multiply).
// Backpressure: stall = start & ~done holds the pipeline; start is sampled only in IDLE.
module ex_muldiv #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            stall
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(ITER - 1);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      func3_q, func3_d;
    logic            neg_q, neg_d, rem_neg_q, rem_neg_d;
    // hi/lo: product {hi,lo} for multiply, {remainder, quotient} for divide
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
    logic            done_q, done_d, busy_q, busy_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] mul_hi, mul_lo, div_hi, div_lo;
`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    function automatic logic [XLEN-1:0] finalize(input logic [2:0] f, input logic neg,
                                                 input logic rem_neg,
                                                 input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   res;
        prod = neg ? -{hi, lo} : {hi, lo};
        case (f)
            3'b000:         res = prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101: res = neg ? -lo : lo;
            default:        res = rem_neg ? -hi : hi;
        endcase
        return res;
    endfunction

    always_comb begin
        a_signed    = func3[2] ? ~func3[0] : (func3 == 3'b001 || func3 == 3'b010);
        b_signed    = func3[2] ? ~func3[0] : (func3 == 3'b001);
        a_neg       = a_signed & rs1_data[XLEN-1];
        b_neg       = b_signed & rs2_data[XLEN-1];
        a_mag       = a_neg ? -rs1_data : rs1_data;
        b_mag       = b_neg ? -rs2_data : rs2_data;
        div_zero    = func3[2] & (rs2_data == '0);
        div_ovf     = func3[2] & ~func3[0] & (rs1_data == MIN_INT) & (rs2_data == '1);
        special_res = div_zero ? (func3[1] ? rs1_data : '1)
                               : (func3[1] ? '0 : MIN_INT);

        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi    = mul_sum[XLEN:1];
        mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
        // restoring step: keep the subtraction only when it does not borrow
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_hi    = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        div_lo    = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
`ifdef FAST_MUL_EN
        fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        func3_d   = func3_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        done_d    = 1'b0;
        busy_d    = 1'b0;
        result_d  = result_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    func3_d   = func3;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    cnt_d     = '0;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else if (!func3[2]) begin
`ifdef FAST_MUL_EN
                        result_d = finalize(func3, a_neg ^ b_neg, 1'b0,
                                            fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
                        done_d   = 1'b1;
                        state_d  = S_DONE;
`else
                        hi_d    = '0;
                        lo_d    = b_mag;
                        opb_d   = a_mag;
                        busy_d  = 1'b1;
                        state_d = S_MUL;
`endif
                    end else begin
                        hi_d    = '0;
                        lo_d    = a_mag;
                        opb_d   = b_mag;
                        busy_d  = 1'b1;
                        state_d = S_DIV;
                    end
                end
                S_MUL, S_DIV: begin
                    hi_d  = (state_q == S_MUL) ? mul_hi : div_hi;
                    lo_d  = (state_q == S_MUL) ? mul_lo : div_lo;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                        result_d = finalize(func3_q, neg_q, rem_neg_q, hi_d, lo_d);
                    end else begin
                        busy_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            func3_q   <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            func3_q   <= func3_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            result_q  <= result_d;
        end
    end

    assign done   = done_q;
    assign busy   = busy_q;
    assign result = result_q;
    assign stall  = start & ~done_q;
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
RV32M multiply/divide unit in the EX stage. It runs alongside the ALU, and its result is muxed onto the ALU-result path that feeds the MEM stage. Multiply and divide are iterative and multi-cycle. While an M-extension instruction is held in EX, the unit asserts a stall request to the hazard unit; EX/MEM advances only on done.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
ITER, 32, iterations per multiply/divide (must equal XLEN)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  level; high while an M-ext instruction occupies EX
func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  32  forwarded operand A (dividend / multiplicand)
rs2_data  input  32  forwarded operand B (divisor / multiplier)
flush  input  1  synchronous abort (branch mispredict / trap)
done  output  1  registered; result valid this cycle, high for exactly 1 cycle
result  output  32  registered result, held until next accept
busy  output  1  registered; high in MUL or DIV state
stall  output  1  combinational: start & ~done

Behaviour:
- Reset (async): state=IDLE, done=0, busy=0, result=0, counter=0, operand/accumulator registers=0.
- States:
  - IDLE: on start, accept. Latch func3, operand magnitudes and sign flags.
    - Special cases go to DONE.
    - func3[2]=0 goes to MUL.
    - Otherwise goes to DIV.
  - MUL / DIV: one iteration per cycle. Counter runs 0..ITER-1. After the iteration with counter==ITER-1, go to DONE.
  - DONE: done=1 and result is valid. Always go to IDLE next cycle, whatever the value of start.
- start is sampled only in IDLE. A held start during DONE is never re-accepted.
- Back-to-back M-ext instructions are accepted from IDLE on the cycle after DONE.
- Latency: let T be the cycle in which start=1 and state=IDLE.
  - Iterative operation: done is high in cycle T+33.
  - Special case: done is high in cycle T+1.
  - stall is high in cycles T..T+32 (33 cycles) and falls in the done cycle.
- Multiply:
  - Radix-2 shift-add on unsigned magnitudes into a 64-bit product.
  - Negate the product if the operand signs differ. Signedness by op:
    - MULH: A signed, B signed.
    - MULHSU: A signed, B unsigned.
    - MULHU and MUL: both unsigned (MUL low 32 bits are sign-agnostic).
  - MUL returns product[31:0]; all MULH variants return product[63:32].
- Divide:
  - Restoring, radix-2, on unsigned magnitudes; 32-bit quotient and remainder.
  - Signed ops: quotient negated if the signs differ; remainder takes the dividend's sign.
- Special cases (no iteration, RISC-V defined results):
  - Divisor==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- flush (any state): next state IDLE, done=0, busy=0, counter=0. result is left unchanged. If flush and start are both high in IDLE, flush wins and nothing is accepted.
- Reset mid-operation: immediate return to reset values; no done is produced.
- Operands are changed only at accept. rs1_data/rs2_data may change during iteration without effect.

Optional Feature:
FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU compute the full 64-bit product combinationally at accept. Flow is IDLE -> DONE, so done is high in T+1 and stall is high only in cycle T. Divide is unchanged.
- Undefined: multiplies take the iterative path (done in T+33). No multiplier array is inferred.

Test Plan:
- DIV 100 / 0xFFFFFFF9 (-7): result 0xFFFFFFF2 (-14), done in T+33, stall high 33 cycles. REM with the same operands: result 2.
- REMU 0xFFFFFFFF % 10: result 5. DIVU 0xFFFFFFFF / 10: result 0x19999999, done in T+33.
- Divide by zero:
  - DIVU 0x1234 / 0: result 0xFFFFFFFF, done in T+1.
  - REM 0xFFFFFF85 / 0: result 0xFFFFFF85.
  - Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000; REM gives 0.
- Multiply:
  - MULH 0x80000000 * 0x80000000: result 0x40000000.
  - MULHSU 0xFFFFFFFF * 0xFFFFFFFF: result 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF * 0xFFFFFFFF: result 0xFFFFFFFE.
  - MUL 0x0001_0001 * 0x0001_0001: result 0x00020001.
  - Done latency: T+33 without FAST_MUL_EN, T+1 with it.
- Flush and reset:
  - Start DIV, pulse flush at T+10: busy=0 at T+11 and done never rises.
  - A new DIVU 9/3 started at T+12 gives 3 at T+45.
  - Assert rst mid-MUL: all outputs return to 0 immediately.
- Back-to-back with start held continuously:
  - DIVU 7/2 gives done/result 3 at T+33.
  - No re-accept in the DONE cycle.
  - Next REMU 7/2 accepted at T+34 gives 1 at T+67.
